// File: rtl/sdram_mport_arb.sv
// Purpose: N-channel round-robin burst arbiter in front of sdram_ctrl; tracks a per-channel address window pointer and ping-pong bank bit.
// Latency: one cycle from ch_req (seen in IDLE) to sdram_wr_req/sdram_rd_req; at least one idle cycle between consecutive grants.
// Backpressure: a request is held until the matching controller ack; the burst runs for as long as that ack stays high.
// Ports: sys_clk/sys_rst (sync, active-high); init_end gates new grants; ch_* are the per-channel request, config and strobe lines;
//        sdram_* carry the request, address, length and write data to the controller and its data-phase acks back.
module sdram_mport_arb #(
    parameter int NUM_CH = 4,
    parameter int AW     = 24,
    parameter int LW     = 10,
    parameter int PP_BIT = 22
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 init_end,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH-1:0]    ch_dir,
    input  logic [NUM_CH*AW-1:0] ch_b_addr,
    input  logic [NUM_CH*AW-1:0] ch_e_addr,
    input  logic [NUM_CH*LW-1:0] ch_burst_len,
    input  logic [NUM_CH-1:0]    ch_pp_en,
    input  logic [NUM_CH-1:0]    ch_addr_rst,
    input  logic [NUM_CH*16-1:0] ch_wr_data,
    output logic [NUM_CH-1:0]    ch_grant,
    output logic [NUM_CH-1:0]    ch_wr_en,
    output logic [NUM_CH-1:0]    ch_rd_valid,
    output logic [NUM_CH-1:0]    ch_done,
    output logic [NUM_CH-1:0]    ch_bank,
    output logic                 sdram_wr_req,
    output logic                 sdram_rd_req,
    output logic [AW-1:0]        sdram_wr_addr,
    output logic [AW-1:0]        sdram_rd_addr,
    output logic [LW-1:0]        sdram_burst_len,
    output logic [15:0]          sdram_wr_data,
    input  logic                 sdram_wr_ack,
    input  logic                 sdram_rd_ack
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       rr_q, gidx_q;
    logic [NUM_CH-1:0]   grant_q, bank_q, pend_q;
    logic                dir_q;
    logic [LW-1:0]       len_q;
    logic [AW-1:0]       addr_q;
    logic [AW-1:0]       ptr_q [NUM_CH];

    // Channel index arithmetic modulo NUM_CH (NUM_CH need not be a power of two).
    function automatic logic [CW-1:0] wrap_idx(input int v);
        return CW'((v >= NUM_CH) ? v - NUM_CH : v);
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [CW-1:0] i);
        logic [NUM_CH-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Round-robin pick: first requester at or after rr_q.
    logic          sel_vld;
    logic [CW-1:0] sel_idx;
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!sel_vld && ch_req[wrap_idx(int'(rr_q) + i)]) begin
                sel_vld = 1'b1;
                sel_idx = wrap_idx(int'(rr_q) + i);
            end
        end
    end

    logic [LW-1:0] sel_len;
    logic [AW-1:0] sel_addr;
    always_comb begin
        sel_len  = ch_burst_len[sel_idx*LW +: LW];
        sel_addr = ptr_q[sel_idx];
        if (ch_pp_en[sel_idx]) begin
            sel_addr[PP_BIT] = bank_q[sel_idx];
        end
    end

    // A zero-length pick is retired straight from IDLE so it cannot stall the rotation.
    logic pick, start, skip;
    assign pick  = (state_q == S_IDLE) && init_end && sel_vld;
    assign start = pick && (sel_len != '0);
    assign skip  = pick && (sel_len == '0);

    logic ack_m;
    assign ack_m = dir_q ? sdram_wr_ack : sdram_rd_ack;

    // Window advance for the granted channel, one extra bit so the end compare cannot wrap.
    logic [AW:0] nxt_sum;
    logic        past_end;
    assign nxt_sum  = {1'b0, ptr_q[gidx_q]} + {{(AW+1-LW){1'b0}}, len_q};
    assign past_end = nxt_sum >= {1'b0, ch_e_addr[gidx_q*AW +: AW]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)  state_d = S_REQ;
            S_REQ:   if (ack_m)  state_d = S_BURST;
            S_BURST: if (!ack_m) state_d = S_DONE;
            S_DONE:              state_d = S_IDLE;
            default:             state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            dir_q   <= 1'b0;
            len_q   <= '0;
            addr_q  <= '0;
            bank_q  <= '0;
            pend_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                ptr_q[c] <= ch_b_addr[c*AW +: AW];
            end
        end else begin
            state_q <= state_d;
            if (start) begin
                grant_q <= onehot(sel_idx);
                gidx_q  <= sel_idx;
                dir_q   <= ch_dir[sel_idx];
                len_q   <= sel_len;
                addr_q  <= sel_addr;
            end else if (skip) begin
                rr_q <= wrap_idx(int'(sel_idx) + 1);
            end
            if (state_q == S_DONE) begin
                grant_q <= '0;
                rr_q    <= wrap_idx(int'(gidx_q) + 1);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (state_q == S_DONE && grant_q[c]) begin
                    // A pointer reset seen during the burst wins over the normal advance.
                    if (pend_q[c] || ch_addr_rst[c]) begin
                        ptr_q[c]  <= ch_b_addr[c*AW +: AW];
                        bank_q[c] <= 1'b0;
                    end else if (past_end) begin
                        ptr_q[c]  <= ch_b_addr[c*AW +: AW];
                        bank_q[c] <= bank_q[c] ^ ch_pp_en[c];
                    end else begin
                        ptr_q[c]  <= nxt_sum[AW-1:0];
                    end
                    pend_q[c] <= 1'b0;
                end else if (ch_addr_rst[c]) begin
                    if (grant_q[c]) begin
                        pend_q[c] <= 1'b1;
                    end else begin
                        ptr_q[c]  <= ch_b_addr[c*AW +: AW];
                        bank_q[c] <= 1'b0;
                    end
                end
            end
        end
    end

    logic [15:0] wdat;
    always_comb begin
        wdat = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_q[c]) wdat = ch_wr_data[c*16 +: 16];
        end
    end

    assign ch_grant        = grant_q;
    assign ch_bank         = bank_q;
    assign ch_wr_en        = {NUM_CH{sdram_wr_ack}} & grant_q;
    assign ch_rd_valid     = {NUM_CH{sdram_rd_ack}} & grant_q;
    assign ch_done         = (state_q == S_DONE) ? grant_q :
                             ((skip && !sys_rst) ? onehot(sel_idx) : '0);
    // Request drops combinationally on the first ack cycle.
    assign sdram_wr_req    = (state_q == S_REQ) && dir_q  && !sdram_wr_ack;
    assign sdram_rd_req    = (state_q == S_REQ) && !dir_q && !sdram_rd_ack;
    assign sdram_wr_addr   = addr_q;
    assign sdram_rd_addr   = addr_q;
    assign sdram_burst_len = len_q;
    assign sdram_wr_data   = wdat;
endmodule

// File: tb/tb_sdram_mport_arb.sv
module tb_sdram_mport_arb;
    localparam int NCH = 4;
    localparam int AW  = 24;
    localparam int LW  = 10;

    logic              sys_clk = 1'b0;
    logic              sys_rst, init_end;
    logic [NCH-1:0]    ch_req, ch_dir, ch_pp_en, ch_addr_rst;
    logic [NCH*AW-1:0] ch_b_addr, ch_e_addr;
    logic [NCH*LW-1:0] ch_burst_len;
    logic [NCH*16-1:0] ch_wr_data;
    logic [NCH-1:0]    ch_grant, ch_wr_en, ch_rd_valid, ch_done, ch_bank;
    logic              sdram_wr_req, sdram_rd_req, sdram_wr_ack, sdram_rd_ack;
    logic [AW-1:0]     sdram_wr_addr, sdram_rd_addr;
    logic [LW-1:0]     sdram_burst_len;
    logic [15:0]       sdram_wr_data;

    logic [AW-1:0] tb_b [NCH];
    logic [AW-1:0] tb_e [NCH];
    logic [LW-1:0] tb_len [NCH];
    logic [15:0]   tb_wd [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_pack
        assign ch_b_addr[c*AW +: AW]    = tb_b[c];
        assign ch_e_addr[c*AW +: AW]    = tb_e[c];
        assign ch_burst_len[c*LW +: LW] = tb_len[c];
        assign ch_wr_data[c*16 +: 16]   = tb_wd[c];
    end

    sdram_mport_arb #(.NUM_CH(NCH), .AW(AW), .LW(LW), .PP_BIT(22)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end),
        .ch_req(ch_req), .ch_dir(ch_dir), .ch_b_addr(ch_b_addr), .ch_e_addr(ch_e_addr),
        .ch_burst_len(ch_burst_len), .ch_pp_en(ch_pp_en), .ch_addr_rst(ch_addr_rst),
        .ch_wr_data(ch_wr_data), .ch_grant(ch_grant), .ch_wr_en(ch_wr_en),
        .ch_rd_valid(ch_rd_valid), .ch_done(ch_done), .ch_bank(ch_bank),
        .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
        .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr),
        .sdram_burst_len(sdram_burst_len), .sdram_wr_data(sdram_wr_data),
        .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tot = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: per-channel window pointer, bank bit, pending reset, rotation pointer.
    logic [AW-1:0] m_ptr [NCH];
    logic [NCH-1:0] m_bank, m_pend;
    int m_rr;
    int m_act = -1;
    bit chk_on = 0;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) m_ptr[c] = tb_b[c];
        m_bank = '0;
        m_pend = '0;
        m_rr   = 0;
    endfunction

    function automatic int model_pick();
        for (int i = 0; i < NCH; i++)
            if (ch_req[(m_rr + i) % NCH]) return (m_rr + i) % NCH;
        return -1;
    endfunction

    function automatic logic [AW-1:0] model_addr(input int c);
        logic [AW-1:0] a;
        a = m_ptr[c];
        if (ch_pp_en[c]) a[22] = m_bank[c];
        return a;
    endfunction

    function automatic void model_done(input int c);
        int unsigned nx;
        if (m_pend[c]) begin
            m_ptr[c]  = tb_b[c];
            m_bank[c] = 1'b0;
        end else begin
            nx = int'(m_ptr[c]) + int'(tb_len[c]);
            if (nx >= int'(tb_e[c])) begin
                m_ptr[c] = tb_b[c];
                if (ch_pp_en[c]) m_bank[c] = ~m_bank[c];
            end else begin
                m_ptr[c] = nx[AW-1:0];
            end
        end
        m_pend[c] = 1'b0;
        m_rr = (c + 1) % NCH;
    endfunction

    // Per-cycle compare against the model's notion of the active channel.
    always begin
        logic [NCH-1:0] eg;
        @(negedge sys_clk);
        #2;
        if (chk_on) begin
            eg = (m_act < 0) ? '0 : NCH'(1) << m_act;
            chk("grant", ch_grant, eg);
            chk("wr_en", ch_wr_en, sdram_wr_ack ? eg : '0);
            chk("rd_valid", ch_rd_valid, sdram_rd_ack ? eg : '0);
            chk("wr_data", sdram_wr_data, (m_act < 0) ? 16'h0 : tb_wd[m_act]);
            chk("req_excl", sdram_wr_req & sdram_rd_req, 0);
        end
    end

    task automatic wait_req(output bit found);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge sys_clk);
            #1;
            if (sdram_wr_req | sdram_rd_req) found = 1;
        end
        if (!found) chk("req_timeout", 0, 1);
    endtask

    task automatic do_burst(input int exp_ch, input int n_ack, input int rst_at,
                            input logic [AW-1:0] lit_addr);
        int g;
        int vcnt;
        bit found;
        logic [NCH-1:0] oh;
        g = model_pick();
        chk("pick", g, exp_ch);
        if (g < 0) return;
        oh = NCH'(1) << g;
        wait_req(found);
        if (!found) return;
        m_act = g;
        chk("req_grant", ch_grant, oh);
        chk("req_wr", sdram_wr_req, ch_dir[g]);
        chk("req_rd", sdram_rd_req, !ch_dir[g]);
        chk("addr_model", ch_dir[g] ? sdram_wr_addr : sdram_rd_addr, model_addr(g));
        chk("addr_lit", ch_dir[g] ? sdram_wr_addr : sdram_rd_addr, lit_addr);
        chk("burst_len", sdram_burst_len, tb_len[g]);
        chk("bank", ch_bank, m_bank);
        if (ch_dir[g]) sdram_wr_ack = 1; else sdram_rd_ack = 1;
        #1;
        chk("req_drop", sdram_wr_req | sdram_rd_req, 0);
        vcnt = 0;
        for (int k = 0; k < n_ack; k++) begin
            if (k > 0) begin
                @(negedge sys_clk);
                #1;
            end
            ch_addr_rst = (k == rst_at) ? oh : '0;
            if (k == rst_at) m_pend[g] = 1'b1;
            if ((ch_dir[g] ? ch_wr_en : ch_rd_valid) == oh) vcnt++;
        end
        @(negedge sys_clk);
        sdram_wr_ack = 0;
        sdram_rd_ack = 0;
        ch_addr_rst  = '0;
        #1;
        chk("strobe_off", ch_dir[g] ? ch_wr_en : ch_rd_valid, 0);
        chk("strobe_cnt", vcnt, n_ack);
        @(negedge sys_clk);
        #1;
        chk("done", ch_done, oh);
        model_done(g);
        @(negedge sys_clk);
        #1;
        m_act = -1;
        chk("done_pulse", ch_done, 0);
    endtask

    int seq_a [5] = '{0, 1, 2, 3, 0};
    logic [AW-1:0] addr_a [5] = '{24'h000000, 24'h001000, 24'h002000, 24'h003000, 24'h000008};
    logic [AW-1:0] addr_b [3] = '{24'h000010, 24'h000018, 24'h400000};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int viol;
        int good;
        bit found;
        for (int c = 0; c < NCH; c++) begin
            tb_b[c]   = AW'(c * 24'h1000);
            tb_e[c]   = AW'(c * 24'h1000 + 32);
            tb_len[c] = 10'd8;
            tb_wd[c]  = 16'hA000 + 16'(c);
        end
        ch_dir = 4'b0101; ch_pp_en = 4'b0001; ch_addr_rst = '0;
        ch_req = 4'hF; init_end = 0; sys_rst = 1;
        sdram_wr_ack = 0; sdram_rd_ack = 0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        #1;
        chk_on = 1;
        chk("rst_grant", ch_grant, 0);
        chk("rst_req", {sdram_wr_req, sdram_rd_req}, 0);
        chk("rst_done", ch_done, 0);
        chk("rst_bank", ch_bank, 0);
        chk("rst_len", sdram_burst_len, 0);
        chk("rst_addr", sdram_wr_addr | sdram_rd_addr, 0);
        sys_rst = 0;

        // init_end low: no request despite all channels requesting.
        viol = 0;
        repeat (100) begin
            @(negedge sys_clk);
            #1;
            if (sdram_wr_req | sdram_rd_req) viol++;
        end
        chk("init_hold", viol, 0);
        init_end = 1;
        @(negedge sys_clk);
        #1;
        chk("init_latency", sdram_wr_req, 1);
        chk("init_grant", ch_grant, 4'b0001);
        m_act = 0;

        // Round robin 0,1,2,3,0.
        for (int k = 0; k < 5; k++) do_burst(seq_a[k], 8, -1, addr_a[k]);

        // Ping-pong wrap on ch0.
        ch_req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            do_burst(0, 4, -1, addr_b[k]);
            if (k == 0) chk("bank_before", ch_bank[0], 0);
            if (k == 1) chk("bank_toggle", ch_bank[0], 1);
        end

        // ch1 read, 8-cycle ack window.
        ch_req = 4'b0010;
        do_burst(1, 8, -1, 24'h001008);

        // ch2 pointer reset mid-burst.
        ch_req = 4'b0100;
        do_burst(2, 4, -1, 24'h002008);
        do_burst(2, 4, 2, 24'h002010);
        do_burst(2, 4, -1, 24'h002000);
        chk("rst_bank2", ch_bank[2], 0);

        // Zero-length burst on ch3 is retired from IDLE.
        ch_req = 4'b1000;
        tb_len[3] = 10'd0;
        good = 0;
        repeat (5) begin
            @(negedge sys_clk);
            #1;
            if (ch_done == 4'b1000 && !(sdram_wr_req | sdram_rd_req)) good++;
        end
        chk("skip", good, 5);
        ch_req = 4'b0000;
        tb_len[3] = 10'd8;
        m_rr = 0;
        @(negedge sys_clk);
        #1;

        // Reset during BURST.
        ch_req = 4'b1000;
        wait_req(found);
        if (found) begin
            m_act = 3;
            chk("g_addr", sdram_rd_addr, 24'h003008);
            sdram_rd_ack = 1;
            repeat (2) @(negedge sys_clk);
            #1;
            sys_rst = 1;
            sdram_rd_ack = 0;
            @(negedge sys_clk);
            #1;
            m_act = -1;
            chk("mid_rst_grant", ch_grant, 0);
            chk("mid_rst_req", {sdram_wr_req, sdram_rd_req}, 0);
            chk("mid_rst_done", ch_done, 0);
            chk("mid_rst_len", sdram_burst_len, 0);
            chk("mid_rst_addr", sdram_rd_addr, 0);
            sys_rst = 0;
            model_reset();
            do_burst(3, 4, -1, 24'h003000);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/sdram_mport_arb.md
Name: sdram_mport_arb

Overview:
- Parametrised N-channel front end for sdram_ctrl; successor to the single write/single read FIFO port of the current SDRAM top.
- Each channel is an independent burst master with its own address window, burst length, direction and optional ping-pong bank toggling.
- Round-robin arbitration grants one channel at a time and drives the controller's wr/rd request, address and burst length.
- Sits between per-channel FIFO controllers (write FIFOs, read FIFOs, camera/VGA ports) and sdram_ctrl, all on sys_clk.

Parameters:
- NUM_CH, 4, number of channels (2..8).
- AW, 24, SDRAM linear address width.
- LW, 10, burst length width.
- PP_BIT, 22, address bit replaced by the channel bank bit when ping-pong is enabled.

Ports:
- sys_clk  in  1  single clock for the whole block.
- sys_rst  in  1  synchronous, active-high reset.
- init_end  in  1  SDRAM initialisation complete; no grant is issued while low.
- ch_req  in  NUM_CH  per-channel burst request (level).
- ch_dir  in  NUM_CH  1=write, 0=read; sampled at grant.
- ch_b_addr  in  NUM_CH*AW  window start address, channel c at [c*AW +: AW].
- ch_e_addr  in  NUM_CH*AW  window end address (exclusive).
- ch_burst_len  in  NUM_CH*LW  burst length; sampled at grant.
- ch_pp_en  in  NUM_CH  ping-pong enable.
- ch_addr_rst  in  NUM_CH  reload pointer to b_addr and clear bank.
- ch_wr_data  in  NUM_CH*16  write data per channel.
- ch_grant  out  NUM_CH  one-hot; held from grant to end of DONE.
- ch_wr_en  out  NUM_CH  = sdram_wr_ack & ch_grant; FIFO read strobe.
- ch_rd_valid  out  NUM_CH  = sdram_rd_ack & ch_grant; FIFO write strobe.
- ch_done  out  NUM_CH  one-cycle pulse at burst end.
- ch_bank  out  NUM_CH  current bank bit per channel.
- sdram_wr_req / sdram_rd_req  out  1  requests to the controller.
- sdram_wr_addr / sdram_rd_addr  out  AW  burst start address.
- sdram_burst_len  out  LW  latched length of the granted channel.
- sdram_wr_data  out  16  ch_wr_data of the granted channel; 0 when idle.
- sdram_wr_ack / sdram_rd_ack  in  1  controller data-phase acknowledges.

Behaviour:
- Reset:
  - All outputs 0; FSM goes to IDLE; round-robin pointer = 0.
  - Each channel pointer ptr[c] loads ch_b_addr[c]; bank[c] = 0.
- FSM states: IDLE, REQ, BURST, DONE.
- IDLE:
  - If init_end and |ch_req, select the first requesting channel at or after rr_ptr, wrapping modulo NUM_CH.
  - Register grant, dir, burst_len and address; go to REQ the next cycle.
  - Latency from ch_req to sdram_*_req is 1 cycle.
- Issued address = ptr[c] with bit PP_BIT replaced by bank[c] when ch_pp_en[c]; otherwise ptr[c] unchanged.
- REQ:
  - Assert sdram_wr_req if dir=1, else sdram_rd_req.
  - On the matching ack = 1, deassert the request in the same cycle (combinational) and go to BURST.
- BURST: stay while ack = 1; on ack falling, go to DONE.
- DONE (1 cycle):
  - Pulse ch_done[c].
  - next = ptr + burst_len, computed at AW+1 bits.
  - If next >= e_addr: ptr = b_addr, and bank toggles if pp_en; otherwise ptr = next.
  - rr_ptr = c+1 mod NUM_CH; drop grant; go to IDLE.
  - Minimum gap between consecutive grants: 1 idle cycle.
- ch_addr_rst[c]:
  - Channel not granted: immediate reload of ptr = b_addr and bank = 0.
  - Channel granted: held pending and applied in DONE, overriding the normal update.
- ch_req dropping after grant is ignored; the burst completes.
- init_end low mid-burst is ignored; only IDLE checks it.
- burst_len = 0: the grant is skipped. IDLE pulses ch_done and advances rr_ptr without issuing a request and without updating ptr.
- sys_rst mid-burst: return to IDLE with all outputs 0 in the next cycle. Abandoning the controller transaction is acceptable because sdram_ctrl shares the reset.

Test Plan:
- NUM_CH=4, channels 0..3 requesting continuously with len=8 -> grants in order 0,1,2,3,0; each grant one-hot; ch_done after each ack window.
- ch0 write, b=0, e=32, len=8, pp_en=1 -> addresses 0, 8, 16, 24, then 0x400000 (bank=1); ch_bank[0] toggles after the 4th done.
- ch1 read, ack high 8 cycles -> ch_rd_valid[1] high exactly 8 cycles; sdram_rd_req falls the cycle ack rises.
- ch_addr_rst[2] asserted mid-burst of ch2 at ptr=16 -> after DONE ptr=b_addr, bank=0; next address = b_addr.
- init_end=0 with all ch_req=1 -> no request for 100 cycles; init_end rises -> sdram_*_req asserted 1 cycle later for ch0.
- sys_rst during BURST -> next cycle all outputs 0, FSM IDLE, ptrs = b_addr.
